// File: rtl/altr_hps_cgate_pkg.sv
// Shared definitions for the HPS clock-gate controller: FSM encoding and defaults.
package altr_hps_cgate_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StCount = 2'd1,
    StGated = 2'd2,
    StWake  = 2'd3
  } cgate_state_e;

  localparam int unsigned WakeDlyDefault = 2;
  localparam int unsigned CntWDefault    = 4;

endpackage

// File: rtl/altr_hps_cgate_idle_cnt.sv
// Idle-cycle counter: load to 1, increment with saturation, clear, and threshold compare.
module altr_hps_cgate_idle_cnt #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic            inc_i,
  input  logic [CntW-1:0] thresh_i,
  output logic            hit_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over load, load over increment; saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CntW'(1);
    end else if (inc_i && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // >= rather than == so a threshold lowered below the running count still gates.
  assign hit_o = (thresh_i != '0) && (cnt_q >= thresh_i);

endmodule

// File: rtl/altr_hps_cgate_ctrl.sv
// Clock-gate controller: gates the downstream clock after a programmable idle period
// and ungates it on activity or an explicit wake request.
module altr_hps_cgate_ctrl
  import altr_hps_cgate_pkg::*;
#(
  parameter int unsigned CNT_W    = CntWDefault,
  parameter int unsigned WAKE_DLY = WakeDlyDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             busy_in,
  input  logic             wake_req,
  input  logic [CNT_W-1:0] cfg_idle_thresh,
  input  logic             cfg_bypass,
  output logic             cg_en,
  output logic             wake_ack,
  output logic             gated_sts
);

  // Wide enough to hold WAKE_DLY, never zero width.
  localparam int unsigned WakeW = $clog2(WAKE_DLY + 2);

  cgate_state_e     state_q, state_d;
  logic [WakeW-1:0] wake_cnt_q, wake_cnt_d;
  logic             cg_en_q, wake_ack_q, gated_sts_q;
  logic             ack_d;
  logic             cnt_clr, cnt_load, cnt_inc, idle_hit;

  altr_hps_cgate_idle_cnt #(
    .CntW (CNT_W)
  ) u_idle_cnt (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (cnt_clr),
    .load_i   (cnt_load),
    .inc_i    (cnt_inc),
    .thresh_i (cfg_idle_thresh),
    .hit_o    (idle_hit)
  );

  // Next-state, idle counter control and wake delay counting.
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    ack_d      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    if (cfg_bypass) begin
      state_d    = StRun;
      wake_cnt_d = '0;
      cnt_clr    = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (!busy_in && (cfg_idle_thresh != '0)) begin
            state_d  = StCount;
            cnt_load = 1'b1;
          end else begin
            cnt_clr = 1'b1;
          end
        end
        StCount: begin
          // A threshold of zero disables gating even if written mid-count.
          if (busy_in || wake_req || (cfg_idle_thresh == '0)) begin
            state_d = StRun;
            cnt_clr = 1'b1;
          end else if (idle_hit) begin
            state_d = StGated;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        StGated: begin
          if (busy_in || wake_req) begin
            state_d    = StWake;
            wake_cnt_d = '0;
          end
        end
        StWake: begin
          if (wake_cnt_q == WakeW'(WAKE_DLY)) begin
            state_d    = StRun;
            wake_cnt_d = '0;
            ack_d      = 1'b1;
          end else begin
            wake_cnt_d = wake_cnt_q + WakeW'(1);
          end
        end
        default: begin
          state_d = StRun;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; outputs come straight from flops so cg_en cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wake_cnt_q  <= '0;
      cg_en_q     <= 1'b1;
      wake_ack_q  <= 1'b0;
      gated_sts_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wake_cnt_q  <= wake_cnt_d;
      cg_en_q     <= cfg_bypass || (state_q != StGated);
      wake_ack_q  <= ack_d;
      gated_sts_q <= !cfg_bypass && (state_q == StGated);
    end
  end

  assign cg_en     = cg_en_q;
  assign wake_ack  = wake_ack_q;
  assign gated_sts = gated_sts_q;

endmodule

// File: tb/tb_altr_hps_cgate_ctrl.sv
// Directed bench for the clock-gate controller (CNT_W=4, WAKE_DLY=2).
module tb_altr_hps_cgate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy_in;
  logic       wake_req;
  logic [3:0] cfg_idle_thresh;
  logic       cfg_bypass;
  logic       cg_en;
  logic       wake_ack;
  logic       gated_sts;

  int n_checks = 0;
  int n_fail   = 0;

  altr_hps_cgate_ctrl #(
    .CNT_W    (4),
    .WAKE_DLY (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .busy_in         (busy_in),
    .wake_req        (wake_req),
    .cfg_idle_thresh (cfg_idle_thresh),
    .cfg_bypass      (cfg_bypass),
    .cg_en           (cg_en),
    .wake_ack        (wake_ack),
    .gated_sts       (gated_sts)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    int acks;
    logic seen_low, seen_sts, seen_ack;

    rst = 1'b1; busy_in = 1'b1; wake_req = 1'b0; cfg_idle_thresh = 4'd3; cfg_bypass = 1'b0;
    step(); step();
    chk("rst_cg_en", cg_en, 1'b1);
    chk("rst_wake_ack", wake_ack, 1'b0);
    chk("rst_gated_sts", gated_sts, 1'b0);
    rst = 1'b0;
    step(); step();
    chk("busy_cg_en", cg_en, 1'b1);

    // T=3: cg_en falls T+1 edges after the first idle sample.
    busy_in = 1'b0;
    step(); chk("idle1_cg_en", cg_en, 1'b1);
    step(); chk("idle2_cg_en", cg_en, 1'b1);
    step(); chk("idle3_cg_en", cg_en, 1'b1);
    step(); chk("idle4_cg_en", cg_en, 1'b1);
    chk("idle4_sts", gated_sts, 1'b0);
    step(); chk("gate_cg_en", cg_en, 1'b0);
    chk("gate_sts", gated_sts, 1'b1);
    step(); chk("gate_hold", cg_en, 1'b0);

    // Wake request: cg_en back one edge later, ack two edges after that.
    wake_req = 1'b1;
    step(); chk("wk0_cg_en", cg_en, 1'b0); chk("wk0_ack", wake_ack, 1'b0);
    step(); chk("wk1_cg_en", cg_en, 1'b1); chk("wk1_ack", wake_ack, 1'b0);
    chk("wk1_sts", gated_sts, 1'b0);
    step(); chk("wk2_ack", wake_ack, 1'b0); chk("wk2_cg_en", cg_en, 1'b1);
    step(); chk("wk3_ack", wake_ack, 1'b1); chk("wk3_cg_en", cg_en, 1'b1);
    wake_req = 1'b0; busy_in = 1'b1;
    step(); chk("wk4_ack", wake_ack, 1'b0);

    // Busy pulse on the second idle cycle restarts the idle count.
    busy_in = 1'b0;
    step(); step();
    busy_in = 1'b1;
    step();
    busy_in = 1'b0;
    step(); step(); step();
    step(); chk("restart_cg_en", cg_en, 1'b1);
    step(); chk("restart_gate", cg_en, 1'b0);

    // Busy and wake together while gated: exactly one ack.
    busy_in = 1'b1; wake_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (wake_ack) acks++;
    end
    chk("dual_one_ack", (acks == 1), 1'b1);
    wake_req = 1'b0;
    step(); chk("dual_cg_en", cg_en, 1'b1);

    // Threshold zero disables gating.
    cfg_idle_thresh = 4'd0; busy_in = 1'b0;
    seen_low = 1'b0; seen_sts = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!cg_en) seen_low = 1'b1;
      if (gated_sts) seen_sts = 1'b1;
    end
    chk("t0_cg_en_low", seen_low, 1'b0);
    chk("t0_gated_sts", seen_sts, 1'b0);

    // Threshold lowered below the running count gates on the next edge.
    cfg_idle_thresh = 4'd3; busy_in = 1'b1;
    step();
    busy_in = 1'b0;
    step(); step();
    cfg_idle_thresh = 4'd1;
    step(); chk("lower_thr_pre", cg_en, 1'b1);
    step(); chk("lower_thr_gate", cg_en, 1'b0);

    // Bypass while gated forces the clock on immediately, no ack.
    cfg_bypass = 1'b1;
    step(); chk("byp_cg_en", cg_en, 1'b1); chk("byp_sts", gated_sts, 1'b0);
    seen_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wake_ack) seen_ack = 1'b1;
      if (!cg_en) seen_low = 1'b1;
    end
    chk("byp_no_ack", seen_ack, 1'b0);
    chk("byp_no_gate", seen_low, 1'b0);
    cfg_bypass = 1'b0; cfg_idle_thresh = 4'd1;
    step(); step(); chk("unbyp_pre", cg_en, 1'b1);
    step(); chk("unbyp_gate", cg_en, 1'b0);

    // Reset mid-WAKE aborts without an ack.
    wake_req = 1'b1;
    step(); step();
    chk("midwake_cg_en", cg_en, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0; wake_req = 1'b0; busy_in = 1'b1;
    chk("rstwk_cg_en", cg_en, 1'b1);
    chk("rstwk_ack", wake_ack, 1'b0);
    seen_ack = 1'b0; seen_low = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wake_ack) seen_ack = 1'b1;
      if (!cg_en) seen_low = 1'b1;
    end
    chk("rstwk_no_ack", seen_ack, 1'b0);
    chk("rstwk_run", seen_low, 1'b0);
    chk("rstwk_sts", gated_sts, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/altr_hps_cgate_ctrl.md
ALTR_HPS_CGATE_CTRL -- requirements
Module: altr_hps_cgate_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the idle threshold and idle counter.
REQ-002 SHALL have parameter WAKE_DLY, default 2, number of cycles cg_en is held high before wake_ack.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 busy_in  input  1  activity indication from the gated domain; 1 = work pending.
REQ-006 wake_req  input  1  level request to ungate; held until wake_ack is seen.
REQ-007 cfg_idle_thresh  input  CNT_W  consecutive idle cycles before gating; 0 = gating disabled.
REQ-008 cfg_bypass  input  1  1 = force clock on, FSM held in RUN.
REQ-009 cg_en  output  1  registered enable, fed to the d input of the downstream active-low latch (e_n = clk).
REQ-010 wake_ack  output  1  registered one-cycle pulse: clock is running again.
REQ-011 gated_sts  output  1  registered, 1 while FSM is in GATED.

Function
REQ-012 FSM states SHALL be RUN, COUNT, GATED, WAKE.
REQ-013 RUN: cg_en=1; if busy_in=0, cfg_bypass=0 and cfg_idle_thresh!=0 -> COUNT with idle_cnt loaded 1.
REQ-014 COUNT: cg_en=1; busy_in=1 or wake_req=1 -> RUN, idle_cnt cleared; else idle_cnt increments.
REQ-015 COUNT -> GATED when idle_cnt equals cfg_idle_thresh while busy_in=0; cg_en is 0 from the next cycle.
REQ-016 Threshold T>0 SHALL yield cg_en falling exactly T+1 cycles after the first busy_in=0 sample in RUN.
REQ-017 idle_cnt SHALL saturate at all-ones; it never wraps to 0.
REQ-018 GATED: cg_en=0, gated_sts=1; busy_in=1 or wake_req=1 -> WAKE.
REQ-019 WAKE: cg_en=1; counts WAKE_DLY cycles, then wake_ack=1 for exactly one cycle and -> RUN.
REQ-020 wake_ack SHALL pulse only on WAKE exit; a wake_req arriving in RUN/COUNT gets no ack.
REQ-021 busy_in and wake_req simultaneous in GATED SHALL produce a single WAKE sequence and one ack.
REQ-022 cfg_bypass=1 in any state SHALL force next state RUN, cg_en=1, idle_cnt=0, no wake_ack.
REQ-023 cfg_idle_thresh change mid-COUNT SHALL take effect on the next comparison; if new value < idle_cnt, -> GATED next cycle.
REQ-024 cg_en SHALL never glitch: it changes only on clk rising edge from a flop.

Reset
REQ-025 rst=1 SHALL force RUN, idle_cnt=0, wake delay count=0, cg_en=1, wake_ack=0, gated_sts=0 on the next edge.
REQ-026 rst asserted mid-GATED or mid-WAKE SHALL abort without issuing wake_ack.
REQ-027 After rst deasserts, first transition evaluates in the following cycle.

Structure
REQ-028 FSM state encoding and the WAKE_DLY default SHALL live in shared package altr_hps_cgate_pkg.
REQ-029 Idle counter SHALL be sub-module altr_hps_cgate_idle_cnt (load, inc, clear, saturate, compare).
REQ-030 Block SHALL contain no latch; the latch stage is a separate instance downstream.

Verification
REQ-031 T=3, busy_in drops to 0 at cycle 10 and stays -> cg_en=0 from cycle 14, gated_sts=1 from cycle 14.
REQ-032 GATED, wake_req=1 at cycle 20 -> cg_en=1 at 21, wake_ack=1 only at cycle 23 (WAKE_DLY=2), RUN at 23.
REQ-033 T=3, busy_in pulses 1 at second idle cycle -> no gating, idle_cnt restarts, cg_en stays 1.
REQ-034 T=0, busy_in=0 for 100 cycles -> cg_en stays 1, gated_sts stays 0.
REQ-035 GATED, busy_in and wake_req rise same cycle -> exactly one wake_ack pulse.
REQ-036 rst=1 for one cycle during WAKE -> cg_en=1, wake_ack never asserted, FSM in RUN.
